// File: rtl/seq_muldiv.sv
// ----------------------------------------------------------------------------
// seq_muldiv
// Iterative multiply/divide unit for the multicycle datapath. One operand bit
// is processed per clock: radix-2 shift-add for multiply, restoring division
// for divide. Signed operations run on magnitudes; the recorded result signs
// are applied in a final FIX cycle, so latency is fixed at WIDTH+1 cycles
// regardless of operand values.
//
// Parameters
//   WIDTH      operand/result width (>= 2)
//   SIGNED_EN  0 forces every operation to unsigned (op[1] ignored)
//
// Ports
//   clock     rising-edge clock
//   reset     asynchronous active-low reset
//   start     request, only honoured while idle
//   op        op[0]: 0 multiply / 1 divide, op[1]: 1 signed
//   a, b      multiplicand/dividend, multiplier/divisor
//   busy      operation in progress (low again in the done cycle)
//   done      one-cycle completion pulse, hi/lo valid in the same cycle
//   div_zero  one-cycle pulse alongside done when a divide has b == 0
//   hi, lo    product {hi,lo}, or remainder (hi) and quotient (lo)
// ----------------------------------------------------------------------------
module seq_muldiv #(
    parameter int WIDTH     = 32,
    parameter int SIGNED_EN = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    // Two's-complement negation of a single-width value.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return (~x) + WIDTH'(1'b1);
    endfunction

    // Two's-complement negation of a double-width value (full product).
    function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] x);
        return (~x) + DW'(1'b1);
    endfunction

    // Architectural state
    state_t            state_r;
    logic [CW-1:0]     cnt_r;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient}.
    logic [DW-1:0]     acc_r;
    logic [WIDTH-1:0]  operand_r;   // multiplicand or divisor magnitude
    logic              is_div_r;
    logic              neg_lo_r;    // product sign / quotient sign
    logic              neg_hi_r;    // product sign / remainder sign

    // Operand decode
    logic              signed_op_s;
    logic              a_neg_s;
    logic              b_neg_s;
    logic [WIDTH-1:0]  a_mag_s;
    logic [WIDTH-1:0]  b_mag_s;
    logic              div_by_zero_s;

    // Iteration datapath
    logic [WIDTH:0]    mul_sum_s;
    logic [WIDTH:0]    div_shift_s;
    logic [WIDTH:0]    div_trial_s;
    logic [DW-1:0]     step_acc_s;

    // Sign fix-up
    logic [DW-1:0]     prod_s;
    logic [WIDTH-1:0]  fix_hi_s;
    logic [WIDTH-1:0]  fix_lo_s;

    // Decode the request: signedness, operand signs and magnitudes.
    always_comb begin
        signed_op_s   = 1'b0;
        a_mag_s       = a;
        b_mag_s       = b;
        if (SIGNED_EN != 0) begin
            signed_op_s = op[1];
        end else begin
            signed_op_s = 1'b0;
        end
        a_neg_s = signed_op_s & a[WIDTH-1];
        b_neg_s = signed_op_s & b[WIDTH-1];
        // The most-negative value negates to itself, which is exactly its
        // unsigned magnitude, so no special case is needed here.
        if (a_neg_s) begin
            a_mag_s = neg_w(a);
        end else begin
            a_mag_s = a;
        end
        if (b_neg_s) begin
            b_mag_s = neg_w(b);
        end else begin
            b_mag_s = b;
        end
        div_by_zero_s = op[0] & (b == {WIDTH{1'b0}});
    end

    // One multiply or divide iteration on the accumulator.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[DW-1:WIDTH]};
        div_shift_s = acc_r[DW-1:WIDTH-1];
        div_trial_s = div_shift_s - {1'b0, operand_r};
        step_acc_s  = acc_r;
        if (acc_r[0]) begin
            mul_sum_s = {1'b0, acc_r[DW-1:WIDTH]} + {1'b0, operand_r};
        end else begin
            mul_sum_s = {1'b0, acc_r[DW-1:WIDTH]};
        end
        if (is_div_r) begin
            // Remainder stays below the divisor, so WIDTH bits hold it; the
            // extra bit only exists in the shifted trial value.
            if (div_trial_s[WIDTH]) begin
                step_acc_s = {div_shift_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end else begin
                step_acc_s = {div_trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end
        end else begin
            // Carry out of the add lands in the top bit after the shift.
            step_acc_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end
    end

    // Apply the recorded result signs to the magnitude result.
    always_comb begin
        prod_s   = acc_r;
        fix_hi_s = acc_r[DW-1:WIDTH];
        fix_lo_s = acc_r[WIDTH-1:0];
        if (neg_lo_r) begin
            prod_s = neg_dw(acc_r);
        end else begin
            prod_s = acc_r;
        end
        if (is_div_r) begin
            if (neg_lo_r) begin
                fix_lo_s = neg_w(acc_r[WIDTH-1:0]);
            end else begin
                fix_lo_s = acc_r[WIDTH-1:0];
            end
            if (neg_hi_r) begin
                fix_hi_s = neg_w(acc_r[DW-1:WIDTH]);
            end else begin
                fix_hi_s = acc_r[DW-1:WIDTH];
            end
        end else begin
            fix_hi_s = prod_s[DW-1:WIDTH];
            fix_lo_s = prod_s[WIDTH-1:0];
        end
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            acc_r     <= {DW{1'b0}};
            operand_r <= {WIDTH{1'b0}};
            is_div_r  <= 1'b0;
            neg_lo_r  <= 1'b0;
            neg_hi_r  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= {WIDTH{1'b0}};
            lo        <= {WIDTH{1'b0}};
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        if (div_by_zero_s) begin
                            // Reported immediately; hi/lo keep the last result.
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end else begin
                            state_r   <= CALC;
                            cnt_r     <= CW'(WIDTH);
                            busy      <= 1'b1;
                            is_div_r  <= op[0];
                            neg_lo_r  <= a_neg_s ^ b_neg_s;
                            if (op[0]) begin
                                acc_r     <= {{WIDTH{1'b0}}, a_mag_s};
                                operand_r <= b_mag_s;
                                neg_hi_r  <= a_neg_s;
                            end else begin
                                acc_r     <= {{WIDTH{1'b0}}, b_mag_s};
                                operand_r <= a_mag_s;
                                neg_hi_r  <= a_neg_s ^ b_neg_s;
                            end
                        end
                    end
                end
                CALC: begin
                    acc_r <= step_acc_s;
                    cnt_r <= cnt_r - CW'(1'b1);
                    if (cnt_r == CW'(1'b1)) begin
                        state_r <= FIX;
                    end
                end
                FIX: begin
                    hi      <= fix_hi_s;
                    lo      <= fix_lo_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CW{1'b0}};
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_muldiv.sv
// ----------------------------------------------------------------------------
// tb_seq_muldiv
// Two instances: WIDTH=32 signed-capable and WIDTH=8 with SIGNED_EN=0.
// A cycle-level behavioural model (plain 64-bit arithmetic plus a countdown to
// the completion cycle) predicts busy/done/div_zero/hi/lo; every falling edge
// the DUT outputs are compared with it. Directed cases with literal results
// pin the model, then randomized operations exercise the rest.
// ----------------------------------------------------------------------------
module tb_seq_muldiv;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b0;

    logic        start0 = 1'b0;
    logic [1:0]  op0    = 2'b00;
    logic [31:0] a0     = 32'h0;
    logic [31:0] b0     = 32'h0;
    logic        busy0, done0, dz0;
    logic [31:0] hi0, lo0;

    logic        start1 = 1'b0;
    logic [1:0]  op1    = 2'b00;
    logic [7:0]  a1     = 8'h0;
    logic [7:0]  b1     = 8'h0;
    logic        busy1, done1, dz1;
    logic [7:0]  hi1, lo1;

    seq_muldiv #(.WIDTH(32), .SIGNED_EN(1)) dut0 (
        .clock(clock), .reset(reset), .start(start0), .op(op0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .div_zero(dz0), .hi(hi0), .lo(lo0)
    );

    seq_muldiv #(.WIDTH(8), .SIGNED_EN(0)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .op(op1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .div_zero(dz1), .hi(hi1), .lo(lo1)
    );

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] phi;   // pending result, published when rem hits 0
        logic [31:0] plo;
        logic [7:0]  rem;   // cycles left until done
    } model_t;

    model_t m0 = '0;
    model_t m1 = '0;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;
    int lat;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference arithmetic: returns {hi, lo}, each masked to w bits.
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] x,
                                           input logic [31:0] y, input int w, input bit sgn_en);
        logic [31:0] mask;
        logic [63:0] ex, ey, p, ph, q, r;
        longint      sx, sy;
        bit          s;
        mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        s  = sgn_en && o[1];
        ex = {32'h0, x & mask};
        ey = {32'h0, y & mask};
        if (s && x[w-1]) ex = ex | {32'hFFFF_FFFF, ~mask};
        if (s && y[w-1]) ey = ey | {32'hFFFF_FFFF, ~mask};
        if (!o[0]) begin
            p  = ex * ey;
            ph = p >> w;
            return {ph[31:0] & mask, p[31:0] & mask};
        end
        if (s) begin
            sx = $signed(ex);
            sy = $signed(ey);
            q  = sx / sy;
            r  = sx % sy;
        end else begin
            q = ex / ey;
            r = ex % ey;
        end
        return {r[31:0] & mask, q[31:0] & mask};
    endfunction

    function automatic model_t model_step(input model_t m, input logic rst_n, input logic st,
                                          input logic [1:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input int w, input bit sgn_en);
        model_t      n;
        logic [63:0] r;
        n      = m;
        n.done = 1'b0;
        n.dz   = 1'b0;
        if (!rst_n) begin
            n = '0;
        end else if (n.rem != 8'd0) begin
            n.rem = n.rem - 8'd1;
            if (n.rem == 8'd0) begin
                n.hi   = n.phi;
                n.lo   = n.plo;
                n.done = 1'b1;
                n.busy = 1'b0;
            end
        end else if (st) begin
            if (o[0] && (y == 32'h0)) begin
                n.done = 1'b1;
                n.dz   = 1'b1;
            end else begin
                r      = ref_op(o, x, y, w, sgn_en);
                n.phi  = r[63:32];
                n.plo  = r[31:0];
                n.rem  = 8'(w + 1);
                n.busy = 1'b1;
            end
        end
        return n;
    endfunction

    // Model advances on the same edges the DUT sees, including async reset.
    always @(posedge clock or negedge reset) begin
        m0 <= model_step(m0, reset, start0, op0, a0, b0, 32, 1'b1);
        m1 <= model_step(m1, reset, start1, op1, {24'h0, a1}, {24'h0, b1}, 8, 1'b0);
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("cycle_w32", {busy0, done0, dz0, hi0, lo0},
                {m0.busy, m0.done, m0.dz, m0.hi, m0.lo});
            chk("cycle_w8", {busy1, done1, dz1, hi1, lo1},
                {m1.busy, m1.done, m1.dz, m1.hi[7:0], m1.lo[7:0]});
        end
    end

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h0000_0001;
            default: return $urandom();
        endcase
    endfunction

    // Called just after a rising edge; returns just after the start edge E0.
    task automatic issue0(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        start0 = 1'b1; op0 = o; a0 = x; b0 = y;
        @(posedge clock); #1;
        start0 = 1'b0;
    endtask

    // lat = rising edges after E0 until done is seen (bounded). Optionally
    // pokes a divide-by-zero start request while the unit is busy.
    task automatic wait0(input int poke_at, output int l);
        l = 0;
        while (!done0 && l < 100) begin
            if (l == poke_at) begin
                start0 = 1'b1; op0 = 2'b01; a0 = 32'd1; b0 = 32'd0;
            end else begin
                start0 = 1'b0;
            end
            @(posedge clock); #1;
            l++;
        end
        start0 = 1'b0;
    endtask

    task automatic issue1(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        start1 = 1'b1; op1 = o; a1 = x; b1 = y;
        @(posedge clock); #1;
        start1 = 1'b0;
    endtask

    task automatic wait1(output int l);
        l = 0;
        while (!done1 && l < 100) begin
            @(posedge clock); #1;
            l++;
        end
    endtask

    task automatic op_check0(input string nm, input logic [1:0] o, input logic [31:0] x,
                             input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo);
        int l;
        issue0(o, x, y);
        wait0(-1, l);
        chk({nm, "_lat"}, l, 33);
        chk({nm, "_hi"}, hi0, ehi);
        chk({nm, "_lo"}, lo0, elo);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1;
        chk_en = 1'b1;
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", {done0, dz0}, 2'b00);
        chk("rst_hi", hi0, 32'h0);
        chk("rst_lo", lo0, 32'h0);
        reset = 1'b1;
        @(posedge clock); #1;

        // Unsigned max * max, plus busy/done framing.
        issue0(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("umul_busy_after_start", busy0, 1'b1);
        wait0(-1, lat);
        chk("umul_lat", lat, 33);
        chk("umul_busy_in_done", busy0, 1'b0);
        chk("umul_hi", hi0, 32'hFFFF_FFFE);
        chk("umul_lo", lo0, 32'h0000_0001);
        @(posedge clock); #1;
        chk("umul_done_one_cycle", done0, 1'b0);

        op_check0("smul", 2'b10, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        op_check0("sdiv", 2'b11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        op_check0("udiv", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14);
        op_check0("sdiv_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);

        // Divide by zero keeps the preloaded result.
        op_check0("preload", 2'b00, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, 32'h5678_0000);
        issue0(2'b01, 32'd5, 32'd0);
        chk("dz_pulse", {done0, dz0, busy0}, 3'b110);
        chk("dz_hi", hi0, 32'h0000_1234);
        chk("dz_lo", lo0, 32'h5678_0000);
        @(posedge clock); #1;
        chk("dz_after", {done0, dz0, busy0}, 3'b000);

        // Start while busy is ignored.
        issue0(2'b00, 32'd7, 32'd9);
        wait0(10, lat);
        chk("midstart_lat", lat, 33);
        chk("midstart_lo", lo0, 32'd63);
        chk("midstart_hi", hi0, 32'd0);

        // Reset after ten iterations aborts the operation.
        issue0(2'b00, 32'd11, 32'd13);
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_outputs", {busy0, done0, dz0}, 3'b000);
        chk("abort_hi", hi0, 32'h0);
        chk("abort_lo", lo0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        op_check0("after_reset", 2'b01, 32'd100, 32'd7, 32'd2, 32'd14);

        // Back-to-back: new start accepted in the done cycle.
        issue0(2'b00, 32'd3, 32'd4);
        wait0(-1, lat);
        chk("b2b_first_lo", lo0, 32'd12);
        issue0(2'b01, 32'd100, 32'd7);
        wait0(-1, lat);
        chk("b2b_second_lat", lat, 33);
        chk("b2b_second_lo", lo0, 32'd14);

        // Narrow unsigned-only instance: op[1] ignored.
        issue1(2'b10, 8'hFF, 8'h02);
        wait1(lat);
        chk("w8_lat", lat, 9);
        chk("w8_hi", hi1, 8'h01);
        chk("w8_lo", lo1, 8'hFE);

        // Randomized operations on the 32-bit instance.
        for (int i = 0; i < 150; i++) begin
            logic [1:0]  o;
            logic [31:0] x, y;
            int          poke, gap;
            o    = 2'($urandom_range(0, 3));
            x    = pick32();
            y    = pick32();
            if ($urandom_range(0, 9) == 0) y = 32'h0;
            poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 30)) : -1;
            issue0(o, x, y);
            wait0(poke, lat);
            chk("rand32_lat", lat, (o[0] && y == 32'h0) ? 0 : 33);
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin
                @(posedge clock); #1;
            end
        end

        // Randomized operations on the 8-bit instance.
        for (int i = 0; i < 100; i++) begin
            logic [1:0] o;
            logic [7:0] x, y;
            o = 2'($urandom_range(0, 3));
            x = 8'($urandom());
            y = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom());
            issue1(o, x, y);
            wait1(lat);
            chk("rand8_lat", lat, (o[0] && y == 8'h00) ? 0 : 9);
        end

        @(posedge clock); #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected end of run");
        $fatal(1, "watchdog expired");
    end

endmodule
